// File: rtl/ones_run_generator.sv
// ones_run_generator: serial stimulus source for the consecutive-ones
// detector path. Each accepted command emits run_len ones followed by
// gap_len zeros on `stream`, one bit per clock. `expect_bingo` marks every
// bit that is the 3rd or later consecutive one, i.e. where a three-ones
// detector must fire.
//
// Build option: define ONES_RUN_GENERATOR_ABORT_EN to add the `abort`
// input and the `aborted` pulse output. An abort ends the active command
// without a done pulse.
module ones_run_generator #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] run_len,
    input  logic [LEN_W-1:0] gap_len,
    output logic             stream,
    output logic             expect_bingo,
    output logic             busy,
    output logic             done
`ifdef ONES_RUN_GENERATOR_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    typedef enum logic [1:0] {
        S_idle  = 2'd0,
        S_ones  = 2'd1,
        S_zeros = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;   // bits left in the current phase
    logic [LEN_W-1:0] gap_reg, gap_next;   // latched gap length
    logic [1:0]       ones_reg, ones_next; // saturating consecutive-ones count
    logic             stream_reg, stream_next;
    logic             bingo_reg, bingo_next;
    logic             done_reg, done_next;
    logic             zero_cmd;            // accepted command with no bits at all
    logic             abort_hit;           // abort taken this edge

`ifdef ONES_RUN_GENERATOR_ABORT_EN
    logic aborted_reg, aborted_next;
    assign abort_hit    = abort && (state_reg != S_idle);
    assign aborted_next = abort_hit;
`else
    assign abort_hit = 1'b0;
`endif

    // State register plus the phase counter and latched gap length.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_reg <= S_idle;
            cnt_reg   <= '0;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gap_reg   <= gap_next;
        end
    end

    // Next-state logic: counters load on acceptance and a phase ends when its
    // counter reaches one, so no counter ever wraps.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gap_next   = gap_reg;
        zero_cmd   = 1'b0;
        unique case (state_reg)
            S_idle: begin
                if (cmd_valid) begin
                    gap_next = gap_len;
                    if (run_len != '0) begin
                        state_next = S_ones;
                        cnt_next   = run_len;
                    end else if (gap_len != '0) begin
                        state_next = S_zeros;
                        cnt_next   = gap_len;
                    end else begin
                        zero_cmd = 1'b1;
                    end
                end
            end
            S_ones: begin
                if (cnt_reg == CNT_ONE) begin
                    if (gap_reg != '0) begin
                        state_next = S_zeros;
                        cnt_next   = gap_reg;
                    end else begin
                        state_next = S_idle;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_zeros: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next = S_idle;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: state_next = S_idle;
        endcase
        if (abort_hit) begin
            state_next = S_idle;
        end
    end

    // Output decode: the registered outputs describe the bit emitted while in
    // state_next, which gives the one-cycle latency from acceptance to bit.
    always_comb begin
        stream_next = (state_next == S_ones);
        ones_next   = 2'd0;
        if (stream_next) begin
            ones_next = (ones_reg == 2'd3) ? 2'd3 : ones_reg + 2'd1;
        end
        // ones_reg counts the ones up to and including the current bit, so
        // two or more means the next one is at least the third in a row.
        bingo_next = stream_next && (ones_reg >= 2'd2);
        done_next  = zero_cmd
                   || ((state_next == S_ones)  && (cnt_next == CNT_ONE) && (gap_next == '0))
                   || ((state_next == S_zeros) && (cnt_next == CNT_ONE));
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            stream_reg <= 1'b0;
            bingo_reg  <= 1'b0;
            done_reg   <= 1'b0;
            ones_reg   <= 2'd0;
        end else begin
            stream_reg <= stream_next;
            bingo_reg  <= bingo_next;
            done_reg   <= done_next;
            ones_reg   <= ones_next;
        end
    end

`ifdef ONES_RUN_GENERATOR_ABORT_EN
    // One-cycle pulse following an accepted abort.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            aborted_reg <= 1'b0;
        end else begin
            aborted_reg <= aborted_next;
        end
    end

    assign aborted = aborted_reg;
`endif

    assign stream       = stream_reg;
    assign expect_bingo = bingo_reg;
    assign done         = done_reg;
    assign busy         = (state_reg != S_idle);
    assign cmd_ready    = (state_reg == S_idle);

endmodule

// File: tb/tb_ones_run_generator.sv
// Scoreboard bench for ones_run_generator: each accepted command pushes the
// expected per-cycle outputs into a queue, popped and compared every cycle.
module tb_ones_run_generator;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] run_len;
    logic [LEN_W-1:0] gap_len;
    logic             stream;
    logic             expect_bingo;
    logic             busy;
    logic             done;
`ifdef ONES_RUN_GENERATOR_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    always #5 clk = ~clk;

    ones_run_generator #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .run_len      (run_len),
        .gap_len      (gap_len),
        .stream       (stream),
        .expect_bingo (expect_bingo),
        .busy         (busy),
        .done         (done)
`ifdef ONES_RUN_GENERATOR_ABORT_EN
        ,
        .abort        (abort),
        .aborted      (aborted)
`endif
    );

    typedef struct packed {
        logic stream;
        logic bingo;
        logic done;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   accepts = 0;
    logic exp_ready_cur = 1'b1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    // Expected bit sequence of one command.
    task automatic push_cmd(input int r, input int g);
        exp_t e;
        if (r == 0 && g == 0) begin
            e = '{stream: 1'b0, bingo: 1'b0, done: 1'b1, busy: 1'b0};
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < r; i++) begin
                e = '{stream: 1'b1, bingo: (i >= 2), done: (g == 0 && i == r - 1), busy: 1'b1};
                exp_q.push_back(e);
            end
            for (int i = 0; i < g; i++) begin
                e = '{stream: 1'b0, bingo: 1'b0, done: (i == g - 1), busy: 1'b1};
                exp_q.push_back(e);
            end
        end
    endtask

    // Advance one clock, update the model, then compare all outputs.
    task automatic tick();
        exp_t e;
        logic acc;
        logic abort_hit;
        @(posedge clk);
        acc = rst_b && cmd_valid && exp_ready_cur;
        abort_hit = 1'b0;
`ifdef ONES_RUN_GENERATOR_ABORT_EN
        abort_hit = rst_b && abort && !exp_ready_cur;
`endif
        if (!rst_b || abort_hit) exp_q.delete();
        if (acc) begin
            push_cmd(int'(run_len), int'(gap_len));
            accepts++;
            $display("cmd %0d accepted run_len=%0d gap_len=%0d t=%0t", accepts, run_len, gap_len, $time);
        end
        #1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check_val("stream", int'(stream), int'(e.stream));
        check_val("expect_bingo", int'(expect_bingo), int'(e.bingo));
        check_val("done", int'(done), int'(e.done));
        check_val("busy", int'(busy), int'(e.busy));
        check_val("cmd_ready", int'(cmd_ready), int'(!e.busy));
`ifdef ONES_RUN_GENERATOR_ABORT_EN
        check_val("aborted", int'(aborted), int'(abort_hit));
`endif
        exp_ready_cur = !e.busy;
    endtask

    // Present a command and return right after the cycle it is accepted.
    task automatic send(input int r, input int g);
        int start;
        start = accepts;
        cmd_valid = 1'b1;
        run_len = LEN_W'(r);
        gap_len = LEN_W'(g);
        for (int i = 0; i < 600 && accepts == start; i++) tick();
        cmd_valid = 1'b0;
        if (accepts == start) check_val("accept_timeout", 0, 1);
    endtask

    // Run until the model has no outstanding bits and the DUT should be idle.
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !exp_ready_cur) && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) check_val("drain_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int start;
        rst_b = 1'b0;
        cmd_valid = 1'b0;
        run_len = '0;
        gap_len = '0;
`ifdef ONES_RUN_GENERATOR_ABORT_EN
        abort = 1'b0;
`endif
        // Reset then idle.
        tick();
        tick();
        rst_b = 1'b1;
        repeat (3) tick();

        // Basic run with gap, short run, zero-length command.
        send(5, 3);
        drain();
        send(2, 0);
        drain();
        send(0, 0);
        drain();

        // Back-to-back with cmd_valid held high.
        start = accepts;
        cmd_valid = 1'b1;
        run_len = 8'd3;
        gap_len = 8'd0;
        for (int i = 0; i < 40 && accepts < start + 2; i++) tick();
        cmd_valid = 1'b0;
        check_val("b2b_accepts", accepts - start, 2);
        drain();

        // Mid-command reset.
        send(10, 4);
        tick();
        tick();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        repeat (3) tick();

        // Gap-only command, maximum-length run, a few random commands.
        send(0, 3);
        drain();
        send(255, 1);
        drain();
        for (int i = 0; i < 4; i++) begin
            send(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
            drain();
        end

`ifdef ONES_RUN_GENERATOR_ABORT_EN
        // Abort after four ones; abort while idle is ignored.
        send(6, 2);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        send(3, 1);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ones_run_generator.md
Name: ones_run_generator

Overview:
- Serial stimulus source for the consecutive-ones detector path. Transmits the pattern that the detector receives.
- Accepts a command through a valid/ready handshake. Each command is a run length of ones plus a gap length of zeros.
- Serialises the command onto a single-bit `stream`, one bit per clock.
- Also drives `expect_bingo`, a reference flag marking where a three-consecutive-ones detector must flag. Scoreboards and loopback checks use it.

Parameters:
- LEN_W, 8, width of `run_len`, `gap_len` and the internal down-counters. Maximum run or gap is 2^LEN_W-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_b  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  generator can accept a command.
- run_len  in  LEN_W  number of consecutive 1 bits to emit.
- gap_len  in  LEN_W  number of 0 bits to emit after the run.
- stream  out  1  serial bit output, registered.
- expect_bingo  out  1  high while `stream` carries the 3rd or later consecutive 1, registered.
- busy  out  1  command in progress (state other than S_idle).
- done  out  1  one-cycle pulse coincident with the last emitted bit of a command.

Behaviour:
- Reset (rst_b low at a rising edge), including mid-command:
  - state = S_idle, stream = 0, expect_bingo = 0, done = 0, busy = 0, cmd_ready = 1.
  - Any in-flight command is discarded.
- FSM states: S_idle, S_ones, S_zeros.
- S_idle:
  - cmd_ready = 1, stream = 0.
  - On cmd_valid && cmd_ready at edge T, `run_len` and `gap_len` are latched.
  - run_len != 0 -> S_ones.
  - run_len == 0 and gap_len != 0 -> S_zeros.
  - Both zero -> stays in S_idle; done pulses at T+1, stream stays 0.
- First bit of an accepted command appears on `stream` in cycle T+1 (latency 1).
- S_ones:
  - stream = 1 for exactly `run_len` cycles; the ones counter decrements each cycle.
  - On the final one: gap_len != 0 -> S_zeros, else -> S_idle.
- S_zeros:
  - stream = 0 for exactly `gap_len` cycles, then -> S_idle.
- cmd_ready = 0 in S_ones and S_zeros.
  - The next command is accepted no earlier than the first S_idle cycle.
  - At least one idle 0 bit therefore separates commands.
  - cmd_valid asserted while busy is held, not dropped; it is accepted on return to S_idle.
- done:
  - High in the same cycle as the last bit of the command: the last 1 if gap_len == 0, otherwise the last 0.
  - Zero-length case as stated under S_idle.
- expect_bingo:
  - Driven by a 2-bit saturating consecutive-ones counter that clears on every 0 emitted.
  - High in any cycle where stream = 1 and this bit is the 3rd or later consecutive 1.
  - For run_len = 5: stream 1,1,1,1,1 with expect_bingo 0,0,1,1,1.
  - run_len <= 2 never raises expect_bingo.
- busy = 1 exactly in S_ones/S_zeros.
- Counters are LEN_W-bit and never wrap: a counter loads on acceptance and the state is left when it reaches 1.

Optional Feature:
- Macro: ONES_RUN_GENERATOR_ABORT_EN.
- When defined:
  - Adds input port `abort` (1 bit) and output port `aborted` (1 bit).
  - abort = 1 at a rising edge in S_ones or S_zeros forces S_idle: stream = 0, expect_bingo = 0 next cycle, done not asserted, `aborted` pulses for one cycle.
  - abort in S_idle has no effect and has priority over nothing; the command handshake is unaffected.
  - rst_b still has priority over abort.
- When undefined: no `abort`/`aborted` ports, and every command runs to completion unless reset.

Test Plan:
- Reset then idle: rst_b low 2 cycles, no commands -> stream = 0, busy = 0, cmd_ready = 1, done = 0 throughout.
- Command run_len = 5, gap_len = 3 accepted at T:
  - stream T+1..T+8 = 1,1,1,1,1,0,0,0.
  - expect_bingo = 0,0,1,1,1,0,0,0.
  - done only at T+8; cmd_ready high again at T+9.
- Short runs: run_len = 2, gap_len = 0 -> stream 1,1, done on the 2nd bit, expect_bingo never asserts. Then run_len = 0, gap_len = 0 -> done at T+1, stream stays 0.
- Back-to-back: cmd_valid held with run_len = 3, gap_len = 0 for two commands -> stream 1,1,1,0,1,1,1. expect_bingo high on the 3rd and 7th bits only; second acceptance occurs in the idle cycle.
- Mid-command reset: run_len = 10, gap_len = 4, rst_b low at cycle T+4 -> stream = 0, busy = 0, cmd_ready = 1 from the reset edge, no done pulse.
- ABORT_EN build: run_len = 6, abort at T+4 -> stream 1,1,1,1 then 0. aborted pulses once, done never asserts, next command is accepted normally.
